fpu_op_dispatch: RTL and testbench

- Issue-side sequencer for the floating-point co-processor.
- Accepts one command per handshake, reads the source operands from the register file, and launches the selected functional unit with a one-cycle start pulse.
- Waits for that unit's done, then drives the write-back select code and write-enable that steer the register write-back mux.
- Commands are strictly serialized: one in flight at a time, so there are no hazards.

---
 rtl/fpu_op_dispatch_if.sv | 40 ++++
 rtl/fpu_op_dispatch.sv | 133 +++++++++++++
 tb/tb_fpu_op_dispatch.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_op_dispatch_if.sv
// Command, register-file read, functional-unit and write-back signals of the
// FPU issue sequencer, bundled for the dispatcher (slave) and its environment (master).
interface fpu_op_dispatch_if #(
  parameter int unsigned REG_AW = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [REG_AW-1:0] cmd_src1;
  logic [REG_AW-1:0] cmd_src2;
  logic [REG_AW-1:0] cmd_dest;
  logic [REG_AW-1:0] rd_addr1;
  logic [REG_AW-1:0] rd_addr2;
  logic [31:0]       rd_data1;
  logic [31:0]       rd_data2;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [7:0]        unit_start;
  logic [7:0]        unit_done;
  logic [3:0]        wb_sel;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic              busy;
  logic              bad_op;
  logic              timeout_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dest,
    input  rd_data1, rd_data2, unit_done,
    output cmd_ready, rd_addr1, rd_addr2, op_a, op_b, unit_start,
    output wb_sel, wb_en, wb_addr, busy, bad_op, timeout_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dest,
    output rd_data1, rd_data2, unit_done,
    input  cmd_ready, rd_addr1, rd_addr2, op_a, op_b, unit_start,
    input  wb_sel, wb_en, wb_addr, busy, bad_op, timeout_err
  );
endinterface

// File: rtl/fpu_op_dispatch.sv
// Serialized FPU issue sequencer: accept, read operands, pulse the unit start,
// wait for its done (bounded by TIMEOUT), then drive one write-back cycle.
module fpu_op_dispatch #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  fpu_op_dispatch_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WB} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] src1_q, src1_d;
  logic [REG_AW-1:0] src2_q, src2_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              bad_op_q, bad_op_d;

  logic       accept;
  logic       cmd_legal;
  logic [2:0] unit_idx;
  logic       done_hit;
  logic       timeout_hit;
  logic [7:0] start_c;
  logic [3:0] wb_sel_c;
  logic       wb_en_c;
  logic       timeout_c;

  assign accept      = (state_q == IDLE) && bus.cmd_valid;
  assign cmd_legal   = (bus.cmd_op != 4'd0) && (bus.cmd_op <= 4'd8);
  // ops 1..8 map to unit bits 0..7; op 8 wraps through 3'b000 - 1 = 7
  assign unit_idx    = op_q[2:0] - 3'd1;
  assign done_hit    = bus.unit_done[unit_idx];
  assign timeout_hit = (cnt_q == 8'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    dest_d    = dest_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    cnt_d     = cnt_q;
    bad_op_d  = 1'b0;
    start_c   = '0;
    wb_sel_c  = '0;
    wb_en_c   = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = bus.cmd_op;
          src1_d   = bus.cmd_src1;
          src2_d   = bus.cmd_src2;
          dest_d   = bus.cmd_dest;
          bad_op_d = (bus.cmd_op > 4'd8);
          if (cmd_legal) state_d = READ;
        end
      end
      READ: begin
        op_a_d  = bus.rd_data1;
        op_b_d  = (op_q inside {4'd1, 4'd2, 4'd3}) ? bus.rd_data2 : '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        start_c = 8'd1 << unit_idx;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wb_sel_c = op_q;
        if (done_hit) begin
          state_d = WB;
        end else if (timeout_hit) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB: begin
        wb_sel_c = op_q;
        wb_en_c  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dest_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cnt_q    <= '0;
      bad_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dest_q   <= dest_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cnt_q    <= cnt_d;
      bad_op_q <= bad_op_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE) && !rst;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rd_addr1    = src1_q;
  assign bus.rd_addr2    = src2_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.unit_start  = start_c;
  assign bus.wb_sel      = wb_sel_c;
  assign bus.wb_en       = wb_en_c;
  assign bus.wb_addr     = (state_q == WB) ? dest_q : '0;
  assign bus.bad_op      = bad_op_q;
  assign bus.timeout_err = timeout_c;

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Self-checking bench for fpu_op_dispatch: directed scenarios plus randomized
// commands, compared against an event-timing model of each command.
module tb_fpu_op_dispatch;
  localparam int unsigned TO = 4;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_op_dispatch_if #(.REG_AW(AW)) bus ();

  fpu_op_dispatch #(.REG_AW(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] regs [16];
  assign bus.rd_data1 = regs[bus.rd_addr1];
  assign bus.rd_data2 = regs[bus.rd_addr2];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  time         last_accept_t;

  function automatic logic [16:0] obs_ctrl();
    return {bus.cmd_ready, bus.busy, bus.unit_start, bus.wb_sel,
            bus.wb_en, bus.timeout_err, bus.bad_op};
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_src1  = '0;
    bus.cmd_src2  = '0;
    bus.cmd_dest  = '0;
    bus.unit_done = '0;
  endtask

  // Issue one command and follow it cycle by cycle. d = cycles from the start
  // pulse to the correct done; noise = other done bits held throughout.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] dst,
                         input int unsigned d, input bit issue_pulse,
                         input logic [7:0] noise, input string tag);
    logic        legal;
    logic [7:0]  bit_m;
    int unsigned dc, endw, last;
    bit          done_ok;
    logic [16:0] exp_v, obs_v;
    logic [31:0] ea, eb;
    legal   = (op >= 4'd1) && (op <= 4'd8);
    bit_m   = legal ? (8'h01 << (op - 4'd1)) : 8'h00;
    dc      = 2 + d;
    done_ok = legal && (d <= TO + 1);
    endw    = done_ok ? dc : 3 + TO;
    last    = !legal ? 2 : (done_ok ? dc + 2 : 4 + TO);
    ea      = regs[s1];
    eb      = (op >= 4'd1 && op <= 4'd3) ? regs[s2] : 32'h0;

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src1  = s1;
    bus.cmd_src2  = s2;
    bus.cmd_dest  = dst;
    bus.unit_done = '0;
    @(posedge clk);
    last_accept_t = $time;
    for (int unsigned k = 1; k <= last; k++) begin
      @(negedge clk);
      if (legal && k < last) begin
        bus.cmd_valid = 1'($urandom);
        bus.cmd_op    = 4'($urandom);
        bus.cmd_src1  = 4'($urandom);
        bus.cmd_src2  = 4'($urandom);
        bus.cmd_dest  = 4'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      bus.unit_done = noise & ~bit_m;
      if (legal && k == dc) bus.unit_done = bus.unit_done | bit_m;
      if (legal && k == 2 && issue_pulse) bus.unit_done = bus.unit_done | bit_m;
      #1;
      if (!legal)
        exp_v = {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, (k == 1 && op > 4'd8)};
      else if (k == 1)
        exp_v = {2'b01, 8'h00, 4'h0, 3'b000};
      else if (k == 2)
        exp_v = {2'b01, bit_m, 4'h0, 3'b000};
      else if (k <= endw)
        exp_v = {2'b01, 8'h00, op, 1'b0, (!done_ok && k == endw), 1'b0};
      else if (done_ok && k == dc + 1)
        exp_v = {2'b01, 8'h00, op, 1'b1, 2'b00};
      else
        exp_v = {2'b10, 15'h0};
      obs_v = obs_ctrl();
      n_chk++;
      if (obs_v !== exp_v)
        $display("FAIL %s ctrl cyc%0d: got {rdy,busy,start,sel,en,tout,bad}=%h expected %h",
                 tag, k, obs_v, exp_v);
      else n_pass++;
      if (k == 1 || k == last) begin
        n_chk++;
        if ({bus.rd_addr1, bus.rd_addr2} !== {s1, s2})
          $display("FAIL %s rd_addr cyc%0d: got %h expected %h", tag, k,
                   {bus.rd_addr1, bus.rd_addr2}, {s1, s2});
        else n_pass++;
      end
      if (legal && k >= 2) begin
        n_chk++;
        if ({bus.op_a, bus.op_b} !== {ea, eb})
          $display("FAIL %s operands cyc%0d: got %h_%h expected %h_%h", tag, k,
                   bus.op_a, bus.op_b, ea, eb);
        else n_pass++;
      end
      if (done_ok && k == dc + 1) begin
        n_chk++;
        if (bus.wb_addr !== dst)
          $display("FAIL %s wb_addr: got %h expected %h", tag, bus.wb_addr, dst);
        else n_pass++;
      end
    end
    bus.unit_done = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (obs_ctrl() !== 17'h0) $display("FAIL reset_during: got %h expected %h", obs_ctrl(), 17'h0);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (obs_ctrl() !== {1'b1, 16'h0})
      $display("FAIL reset_after ctrl: got %h expected %h", obs_ctrl(), {1'b1, 16'h0});
    else n_pass++;
    n_chk++;
    if ({bus.op_a, bus.op_b, bus.wb_addr, bus.rd_addr1, bus.rd_addr2} !== 76'h0)
      $display("FAIL reset_after data: got %h expected 0",
               {bus.op_a, bus.op_b, bus.wb_addr, bus.rd_addr1, bus.rd_addr2});
    else n_pass++;
  endtask

  task automatic test_add();
    regs[1] = 32'h3F80_0000;
    regs[2] = 32'h4000_0000;
    run_cmd(4'd1, 4'd1, 4'd2, 4'd3, 2, 1'b0, 8'h00, "add");
  endtask

  task automatic test_unit_select();
    regs[5] = 32'hC049_0FDB;
    regs[6] = 32'h1234_5678;
    run_cmd(4'd4, 4'd5, 4'd6, 4'd7, 1, 1'b0, 8'h00, "neg");
    run_cmd(4'd8, 4'd6, 4'd5, 4'd5, 3, 1'b0, 8'h00, "mov");
    run_cmd(4'd7, 4'd9, 4'd9, 4'd9, 2, 1'b0, 8'h00, "sram");
  endtask

  task automatic test_none_and_bad();
    run_cmd(4'd0, 4'd2, 4'd3, 4'd4, 1, 1'b0, 8'hFF, "none");
    run_cmd(4'd12, 4'd5, 4'd6, 4'd7, 1, 1'b0, 8'hFF, "bad12");
  endtask

  task automatic test_wrong_done();
    regs[10] = 32'h4049_0FDB;
    regs[11] = 32'h3F00_0000;
    run_cmd(4'd3, 4'd10, 4'd11, 4'd12, 3, 1'b1, 8'h01, "mul_wrong_done");
  endtask

  task automatic test_timeout();
    run_cmd(4'd2, 4'd1, 4'd2, 4'd8, TO + 2, 1'b0, 8'h00, "timeout");
    run_cmd(4'd2, 4'd3, 4'd4, 4'd9, TO + 1, 1'b0, 8'h00, "done_at_limit");
  endtask

  task automatic test_reset_in_wait();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd1;
    bus.cmd_src1  = 4'd1;
    bus.cmd_src2  = 4'd2;
    bus.cmd_dest  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (bus.wb_sel !== 4'd1) $display("FAIL rst_wait pre wb_sel: got %h expected 1", bus.wb_sel);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (obs_ctrl() !== 17'h0) $display("FAIL rst_wait during: got %h expected 0", obs_ctrl());
    else n_pass++;
    n_chk++;
    if ({bus.op_a, bus.op_b} !== 64'h0) $display("FAIL rst_wait operands: got %h expected 0", {bus.op_a, bus.op_b});
    else n_pass++;
    rst = 1'b0;
    bus.unit_done = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.unit_done = '0;
      #1;
      n_chk++;
      if (obs_ctrl() !== {1'b1, 16'h0})
        $display("FAIL rst_wait after cyc%0d: got %h expected %h", i, obs_ctrl(), {1'b1, 16'h0});
      else n_pass++;
    end
    regs[1] = 32'h3F80_0000;
    regs[2] = 32'h4000_0000;
    run_cmd(4'd1, 4'd1, 4'd2, 4'd3, 1, 1'b0, 8'h00, "add_after_rst");
  endtask

  task automatic test_back_to_back();
    time t0;
    run_cmd(4'd5, 4'd4, 4'd4, 4'd4, 1, 1'b0, 8'h00, "b2b_first");
    t0 = last_accept_t;
    run_cmd(4'd6, 4'd7, 4'd8, 4'd15, 1, 1'b0, 8'h00, "b2b_second");
    n_chk++;
    if (last_accept_t - t0 !== 50)
      $display("FAIL b2b interval: got %0t expected 50", last_accept_t - t0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 15)] = $urandom;
      run_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
              $urandom_range(1, 7), 1'($urandom), 8'($urandom), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_unit_select();
    test_none_and_bad();
    test_wrong_done();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
